// File: rtl/hex_calc_pkg.sv
// Shared codes for the hex calculator: operator/data-type encodings,
// ALU FSM states and the default operand width.
package hex_calc_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_MUL = 5'd3;
  localparam logic [4:0] OP_DIV = 5'd4;

  localparam logic [3:0] TYPE_SIGNED   = 4'd1;
  localparam logic [3:0] TYPE_UNSIGNED = 4'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    DIV_RUN = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } alu_state_t;

endpackage

// File: rtl/hex_alu_div.sv
// Unsigned iterative restoring divider: one quotient bit per cycle,
// DATA_W cycles after start; done flags the cycle of the final step.
module hex_alu_div #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W);

  logic              run;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] dvs;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;

  // quotient doubles as the dividend shift register
  always_comb begin
    trial = {remainder, quotient[DATA_W-1]};
    diff  = trial - {1'b0, dvs};
  end

  assign done = run && (cnt == CW'(DATA_W-1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      run       <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      run       <= 1'b1;
      cnt       <= '0;
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (run) begin
      remainder <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
      quotient  <= {quotient[DATA_W-2:0], ~diff[DATA_W]};
      cnt       <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/hex_alu.sv
// Hex calculator execution stage: add/sub/mul/div, signed or unsigned.
// Define HEX_ALU_SEQ_MUL_EN for a shift-add multiplier sharing DIV_RUN/DIV_FIX.
module hex_alu
  import hex_calc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                parser_done,
  input  logic [4:0]          operator,
  input  logic [3:0]          data_type,
  input  logic [DATA_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic                busy,
  output logic                calc_done,
  output logic [2*DATA_W-1:0] result,
  output logic [DATA_W-1:0]   remainder,
  output logic                div_by_zero,
  output logic                op_err
);

  localparam int RW = 2*DATA_W;

  alu_state_t        state;
  logic [4:0]        op_q;
  logic              sgn_q;
  logic [DATA_W-1:0] a_q, b_q;

  logic              a_neg, b_neg;
  logic [RW-1:0]     a_ext, b_ext;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [RW-1:0]     q_fix;
  logic [DATA_W-1:0] r_fix;

  logic              div_start, div_done;
  logic [DATA_W-1:0] div_q, div_r;

  always_comb begin
    a_neg = sgn_q & a_q[DATA_W-1];
    b_neg = sgn_q & b_q[DATA_W-1];
    a_ext = {{DATA_W{a_neg}}, a_q};
    b_ext = {{DATA_W{b_neg}}, b_q};
    a_mag = a_neg ? (DATA_W'(0) - a_q) : a_q;
    b_mag = b_neg ? (DATA_W'(0) - b_q) : b_q;
    // truncate toward zero: quotient sign from both, remainder from dividend
    q_fix = (a_neg ^ b_neg) ? (RW'(0) - {{DATA_W{1'b0}}, div_q}) : {{DATA_W{1'b0}}, div_q};
    r_fix = a_neg ? (DATA_W'(0) - div_r) : div_r;
  end

  assign div_start = (state == EXEC) && (op_q == OP_DIV) && (b_q != '0);

  hex_alu_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

`ifdef HEX_ALU_SEQ_MUL_EN
  localparam int CW = $clog2(DATA_W);
  logic              mul_mode;
  logic [RW-1:0]     mcand, prod;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0]     mcnt;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      op_q        <= '0;
      sgn_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      busy        <= 1'b0;
      calc_done   <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      op_err      <= 1'b0;
`ifdef HEX_ALU_SEQ_MUL_EN
      mul_mode    <= 1'b0;
      mcand       <= '0;
      prod        <= '0;
      mplier      <= '0;
      mcnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          calc_done <= 1'b0;
          if (parser_done) begin
            op_q        <= operator;
            sgn_q       <= (data_type == TYPE_SIGNED);
            a_q         <= src1;
            b_q         <= src2;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            op_err      <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          state     <= DONE;
          remainder <= '0;
          case (op_q)
            OP_ADD: result <= a_ext + b_ext;
            OP_SUB: result <= a_ext - b_ext;
`ifdef HEX_ALU_SEQ_MUL_EN
            OP_MUL: begin
              mul_mode <= 1'b1;
              mcand    <= RW'(a_mag);
              mplier   <= b_mag;
              prod     <= '0;
              mcnt     <= '0;
              state    <= DIV_RUN;
            end
`else
            OP_MUL: result <= a_ext * b_ext;
`endif
            OP_DIV: begin
              if (b_q == '0) begin
                result      <= '0;
                remainder   <= a_q;
                div_by_zero <= 1'b1;
              end else begin
`ifdef HEX_ALU_SEQ_MUL_EN
                mul_mode <= 1'b0;
`endif
                state <= DIV_RUN;
              end
            end
            default: begin
              result <= '0;
              op_err <= 1'b1;
            end
          endcase
        end
        DIV_RUN: begin
`ifdef HEX_ALU_SEQ_MUL_EN
          if (mul_mode) begin
            prod   <= prod + (mplier[0] ? mcand : RW'(0));
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mcnt   <= mcnt + 1'b1;
            if (mcnt == CW'(DATA_W-1)) state <= DIV_FIX;
          end else if (div_done) state <= DIV_FIX;
`else
          if (div_done) state <= DIV_FIX;
`endif
        end
        DIV_FIX: begin
          state <= DONE;
`ifdef HEX_ALU_SEQ_MUL_EN
          if (mul_mode) begin
            result    <= (a_neg ^ b_neg) ? (RW'(0) - prod) : prod;
            remainder <= '0;
          end else begin
            result    <= q_fix;
            remainder <= r_fix;
          end
`else
          result    <= q_fix;
          remainder <= r_fix;
`endif
        end
        DONE: begin
          calc_done <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_alu.sv
// Directed bench for hex_alu: latency, arithmetic, error flags,
// ignored restarts and asynchronous reset mid-divide.
module tb_hex_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          parser_done = 1'b0;
  logic [4:0]    operator = '0;
  logic [3:0]    data_type = '0;
  logic [W-1:0]  src1 = '0, src2 = '0;
  logic          busy, calc_done, div_by_zero, op_err;
  logic [2*W-1:0] result;
  logic [W-1:0]  remainder;

  int checks = 0;
  int errors = 0;

`ifdef HEX_ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W + 3;
`else
  localparam int MUL_LAT = 2;
`endif

  hex_alu #(.DATA_W(W)) dut (
    .clk(clk), .n_rst(n_rst), .parser_done(parser_done), .operator(operator),
    .data_type(data_type), .src1(src1), .src2(src2), .busy(busy),
    .calc_done(calc_done), .result(result), .remainder(remainder),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  always #5 clk = ~clk;

  // Pulses parser_done, scrambles the inputs after capture, and returns
  // the cycles until calc_done (-1 on timeout) plus busy just after capture.
  task automatic issue(input logic [4:0] op, input logic [3:0] ty,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output logic busy0);
    @(negedge clk);
    operator = op; data_type = ty; src1 = a; src2 = b; parser_done = 1'b1;
    @(posedge clk); #1;
    parser_done = 1'b0;
    busy0 = busy;
    src1 = ~a; src2 = ~b; data_type = (ty == 4'd1) ? 4'd2 : 4'd1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (calc_done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, calc_done, result, remainder, div_by_zero, op_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h rem=%h dz=%b oe=%b, want all 0",
               busy, calc_done, result, remainder, div_by_zero, op_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
  endtask

  task automatic test_add;
    int lat; logic b0;
    issue(5'd1, 4'd2, 16'hFFFF, 16'h0001, lat, b0);
    checks++;
    if (b0 !== 1'b1) begin errors++; $display("FAIL add_busy: got %b want 1", b0); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++;
    if (result !== 32'h0001_0000 || div_by_zero !== 1'b0 || op_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_result: got res=%h dz=%b oe=%b busy=%b want 00010000 0 0 0",
               result, div_by_zero, op_err, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (calc_done !== 1'b0 || result !== 32'h0001_0000) begin
      errors++;
      $display("FAIL add_hold: got done=%b res=%h want 0 00010000", calc_done, result);
    end
  endtask

  task automatic test_sub_mul;
    int lat; logic b0;
    issue(5'd2, 4'd1, 16'h0003, 16'h0005, lat, b0);
    checks++;
    if (result !== 32'hFFFF_FFFE || lat !== 2) begin
      errors++; $display("FAIL signed_sub: got res=%h lat=%0d want FFFFFFFE 2", result, lat);
    end
    issue(5'd3, 4'd2, 16'hFFFE, 16'h0003, lat, b0);
    checks++;
    if (result !== 32'h0002_FFFA || remainder !== 16'h0 || lat !== MUL_LAT) begin
      errors++;
      $display("FAIL unsigned_mul: got res=%h rem=%h lat=%0d want 0002FFFA 0000 %0d",
               result, remainder, lat, MUL_LAT);
    end
    issue(5'd3, 4'd1, 16'hFFFE, 16'h0003, lat, b0);
    checks++;
    if (result !== 32'hFFFF_FFFA || lat !== MUL_LAT) begin
      errors++;
      $display("FAIL signed_mul: got res=%h lat=%0d want FFFFFFFA %0d", result, lat, MUL_LAT);
    end
    issue(5'd1, 4'd7, 16'h8000, 16'h8000, lat, b0);
    checks++;
    if (result !== 32'h0001_0000) begin
      errors++; $display("FAIL other_type_unsigned: got %h want 00010000", result);
    end
  endtask

  task automatic test_div;
    int lat; logic b0;
    issue(5'd4, 4'd1, 16'hFFF9, 16'h0002, lat, b0);
    checks++;
    if (lat !== 19) begin errors++; $display("FAIL div_latency: got %0d want 19", lat); end
    checks++;
    if (result !== 32'hFFFF_FFFD || remainder !== 16'hFFFF) begin
      errors++; $display("FAIL signed_div: got res=%h rem=%h want FFFFFFFD FFFF", result, remainder);
    end
    issue(5'd4, 4'd2, 16'hFFFF, 16'h0010, lat, b0);
    checks++;
    if (result !== 32'h0000_0FFF || remainder !== 16'h000F || lat !== 19) begin
      errors++;
      $display("FAIL unsigned_div: got res=%h rem=%h lat=%0d want 00000FFF 000F 19",
               result, remainder, lat);
    end
    issue(5'd4, 4'd1, 16'h8000, 16'hFFFF, lat, b0);
    checks++;
    if (result !== 32'h0000_8000 || remainder !== 16'h0 || div_by_zero !== 1'b0 || op_err !== 1'b0) begin
      errors++;
      $display("FAIL div_min_by_neg1: got res=%h rem=%h dz=%b oe=%b want 00008000 0000 0 0",
               result, remainder, div_by_zero, op_err);
    end
    issue(5'd4, 4'd1, 16'h0007, 16'hFFFE, lat, b0);
    checks++;
    if (result !== 32'hFFFF_FFFD || remainder !== 16'h0001) begin
      errors++; $display("FAIL div_pos_by_neg: got res=%h rem=%h want FFFFFFFD 0001", result, remainder);
    end
  endtask

  task automatic test_div_zero;
    int lat; logic b0;
    issue(5'd4, 4'd2, 16'h1234, 16'h0000, lat, b0);
    checks++;
    if (div_by_zero !== 1'b1 || result !== 32'h0 || remainder !== 16'h1234 || lat !== 2) begin
      errors++;
      $display("FAIL div_zero: got dz=%b res=%h rem=%h lat=%0d want 1 0 1234 2",
               div_by_zero, result, remainder, lat);
    end
    issue(5'd1, 4'd2, 16'h0010, 16'h0020, lat, b0);
    checks++;
    if (div_by_zero !== 1'b0 || result !== 32'h0000_0030 || remainder !== 16'h0) begin
      errors++;
      $display("FAIL div_zero_clear: got dz=%b res=%h rem=%h want 0 00000030 0000",
               div_by_zero, result, remainder);
    end
  endtask

  task automatic test_illegal_ignore;
    int lat, pulses; logic b0;
    issue(5'd0, 4'd2, 16'h1111, 16'h2222, lat, b0);
    checks++;
    if (op_err !== 1'b1 || result !== 32'h0 || div_by_zero !== 1'b0 || lat !== 2) begin
      errors++;
      $display("FAIL illegal_op: got oe=%b res=%h dz=%b lat=%0d want 1 0 0 2",
               op_err, result, div_by_zero, lat);
    end
    @(negedge clk);
    operator = 5'd4; data_type = 4'd2; src1 = 16'h0064; src2 = 16'h0007; parser_done = 1'b1;
    @(posedge clk); #1 parser_done = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    operator = 5'd1; src1 = 16'h0001; src2 = 16'h0001; parser_done = 1'b1;
    @(posedge clk); #1 parser_done = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (calc_done) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ignore_restart_pulses: got %0d want 1", pulses); end
    checks++;
    if (result !== 32'h0000_000E || remainder !== 16'h0002 || op_err !== 1'b0) begin
      errors++;
      $display("FAIL ignore_restart_result: got res=%h rem=%h oe=%b want 0000000E 0002 0",
               result, remainder, op_err);
    end
  endtask

  task automatic test_reset_mid_div;
    int lat, pulses; logic b0;
    @(negedge clk);
    operator = 5'd4; data_type = 4'd2; src1 = 16'hABCD; src2 = 16'h0003; parser_done = 1'b1;
    @(posedge clk); #1 parser_done = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk) n_rst = 1'b0;
    #1;
    checks++;
    if ({busy, calc_done, result, remainder, div_by_zero, op_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_div: got busy=%b done=%b res=%h rem=%h dz=%b oe=%b want all 0",
               busy, calc_done, result, remainder, div_by_zero, op_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) n_rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (calc_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_no_done: got %0d pulses want 0", pulses); end
    issue(5'd1, 4'd2, 16'h0002, 16'h0003, lat, b0);
    checks++;
    if (result !== 32'h0000_0005 || lat !== 2) begin
      errors++; $display("FAIL add_after_reset: got res=%h lat=%0d want 00000005 2", result, lat);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub_mul;
    test_div;
    test_div_zero;
    test_illegal_ignore;
    test_reset_mid_div;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_alu.md
Name: hex_alu

Overview:
Execution stage of the UART hex calculator, directly downstream of the command decoder. It captures src1, src2, operator and data_type on the decoder's one-cycle parser_done pulse and executes add, subtract, multiply or divide in signed or unsigned mode. It returns a 2*DATA_W result with a one-cycle calc_done pulse to the result encoder/UART TX path.

Parameters:
DATA_W, 16, operand width in bits; result is 2*DATA_W, remainder is DATA_W.

Ports:
clk  input  1  system clock, all logic rising-edge
n_rst  input  1  asynchronous active-low reset
parser_done  input  1  start pulse from decoder, one cycle wide
operator  input  5  operator code: 1 = +, 2 = -, 3 = *, 4 = /; any other value is illegal
data_type  input  4  1 = signed, 2 = unsigned; any other value is treated as unsigned
src1  input  DATA_W  left operand
src2  input  DATA_W  right operand
busy  output  1  high from capture until calc_done
calc_done  output  1  one-cycle pulse; result and flags are valid from this cycle until the next start
result  output  2*DATA_W  quotient, product, sum or difference, sign- or zero-extended
remainder  output  DATA_W  division remainder; 0 for non-divide operations
div_by_zero  output  1  set with calc_done when divisor is 0; cleared on the next start
op_err  output  1  set with calc_done on an illegal operator; cleared on the next start

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset is asynchronous and takes effect at any state, including mid-divide; no calc_done is produced for the aborted operation.
- FSM states: IDLE, EXEC, DIV_RUN, DIV_FIX, DONE.
- IDLE:
  - When parser_done=1, latch all inputs, set busy=1, clear div_by_zero and op_err.
  - Next state: EXEC.
- EXEC:
  - Add, sub, mul: write result, go to DONE.
  - Illegal operator: result=0, op_err=1, go to DONE.
  - Divide with src2=0: result=0, remainder=src1, div_by_zero=1, go to DONE.
  - Otherwise load |dividend| and |divisor| (absolute value only in signed mode), clear the counter, go to DIV_RUN.
- DIV_RUN: one restoring-division step per cycle for exactly DATA_W cycles, then go to DIV_FIX.
- DIV_FIX: apply sign correction, write result and remainder, go to DONE.
- DONE: calc_done=1 and busy=0 for this single cycle, then return to IDLE.
- Latency, counted from the clock edge that samples parser_done to calc_done high:
  - Add, sub, mul, illegal operator, divide-by-zero: 2 cycles.
  - Divide: DATA_W+3 cycles (19 at default).
- Arithmetic rules:
  - Signed mode sign-extends operands to 2*DATA_W; unsigned mode zero-extends them.
  - Add and sub wrap modulo 2^(2*DATA_W); there is no overflow flag.
  - Multiply gives the full 2*DATA_W product.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend. The quotient is sign-extended into result.
  - Signed -2^(DATA_W-1) / -1 = +2^(DATA_W-1) is representable in result; no error is flagged.
- Boundary conditions:
  - parser_done while busy=1 or during DONE is ignored; no queueing.
  - Inputs changing after capture have no effect.
  - result, remainder and flags hold their values in IDLE.

Optional Feature:
HEX_ALU_SEQ_MUL_EN:
- Defined: multiply runs as a shift-add over DATA_W cycles, reusing DIV_RUN/DIV_FIX with a mode bit. Multiply latency becomes DATA_W+3, and sign correction is applied in DIV_FIX.
- Undefined: single-cycle combinational multiplier in EXEC, latency 2.
- Results are bit-identical in both builds.

Decomposition:
- Shared package hex_calc_pkg:
  - Operator codes: OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4.
  - Data-type codes: TYPE_SIGNED=1, TYPE_UNSIGNED=2.
  - FSM state encoding.
  - Default DATA_W.
- One sub-module, hex_alu_div: an unsigned iterative restoring divider core with ports start, dividend, divisor, done, quotient, remainder. Sign handling stays in hex_alu.

Test Plan:
1. Unsigned add: type=2, op=1, 0xFFFF + 0x0001 -> result=0x00010000, calc_done 2 cycles after parser_done, flags 0.
2. Signed sub: type=1, op=2, 0x0003 - 0x0005 -> result=0xFFFFFFFE. Unsigned mul: 0xFFFE * 0x0003 -> 0x0002FFFA. Signed mul: same operands -> 0xFFFFFFFA.
3. Signed divide: 0xFFF9 / 0x0002 -> result=0xFFFFFFFD, remainder=0xFFFF, calc_done exactly 19 cycles after parser_done. Unsigned divide: 0xFFFF / 0x0010 -> result=0x00000FFF, remainder=0x000F.
4. Divide by zero: 0x1234 / 0x0000 -> div_by_zero=1, result=0, remainder=0x1234, latency 2. A following legal add clears div_by_zero.
5. Illegal operator op=0 -> op_err=1, result=0. A second parser_done issued 5 cycles into a divide is ignored, giving exactly one calc_done.
6. Assert n_rst low 8 cycles into a divide -> busy=0 and all outputs 0 immediately, no calc_done. After release, a new add completes normally.
